// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, default operand width and FIFO entry layout.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  // FIFO entry packs {carry, zero, result}
  localparam int ENTRY_W   = ALU_WIDTH + 2;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_INC   = 4'h2;
  localparam logic [3:0] OP_DEC   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOR   = 4'h7;
  localparam logic [3:0] OP_NAND  = 4'h8;
  localparam logic [3:0] OP_XNOR  = 4'h9;
  localparam logic [3:0] OP_NOTA  = 4'hA;
  localparam logic [3:0] OP_SHL   = 4'hB;
  localparam logic [3:0] OP_SHR   = 4'hC;
  localparam logic [3:0] OP_ROL   = 4'hD;
  localparam logic [3:0] OP_ROR   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

endpackage

// File: rtl/alu_core.sv
// Combinational 16-function ALU: opcode -> {result, carry}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // One extra bit so carry-out / borrow fall out of the top of the sum
  logic [WIDTH:0] ext;

  always_comb begin
    ext    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OP_INC: begin
        ext    = {1'b0, a} + (WIDTH+1)'(1);
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - (WIDTH+1)'(1);
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOR:   result = ~(a | b);
      OP_NAND:  result = ~(a & b);
      OP_XNOR:  result = ~(a ^ b);
      OP_NOTA:  result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_ROL: begin
        result = {a[WIDTH-2:0], a[WIDTH-1]};
        carry  = a[WIDTH-1];
      end
      OP_ROR: begin
        result = {a[0], a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_responder.sv
// Valid/ready wrapper around alu_core: one registered compute stage feeding a
// small result FIFO, plus a wrapping count of delivered results.
module alu_req_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 2;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [EW-1:0]    entry, head;
  logic             push, pop;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (alu_res),
    .carry  (alu_carry)
  );

  assign entry = {alu_carry, (alu_res == '0), alu_res};

  // No pass-through: a full FIFO refuses input even when a pop is pending
  assign in_ready  = !rst && (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head       = mem[rd_ptr];
  assign out_carry  = head[EW-1];
  assign out_zero   = head[EW-2];
  assign out_result = head[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      op_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        op_count <= op_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_responder.sv
// Directed bench for alu_req_responder: inputs driven and outputs sampled on negedge.
module tb_alu_req_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_op, in_a, in_b;
  logic       out_valid, out_ready;
  logic [3:0] out_result;
  logic       out_carry, out_zero;
  logic [7:0] op_count;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_req_responder #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .op_count   (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Reference written arithmetically, independent of the RTL bit slicing
  function automatic logic [4:0] ref_alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, r, c;
    ai = int'(a); bi = int'(b); r = 0; c = 0;
    case (op)
      4'h0: begin r = (ai + bi) % 16; c = (ai + bi > 15) ? 1 : 0; end
      4'h1: begin r = (ai - bi + 16) % 16; c = (ai < bi) ? 1 : 0; end
      4'h2: begin r = (ai + 1) % 16; c = (ai == 15) ? 1 : 0; end
      4'h3: begin r = (ai + 15) % 16; c = (ai == 0) ? 1 : 0; end
      4'h4: r = int'(a & b);
      4'h5: r = int'(a | b);
      4'h6: r = int'(a ^ b);
      4'h7: r = 15 - int'(a | b);
      4'h8: r = 15 - int'(a & b);
      4'h9: r = 15 - int'(a ^ b);
      4'hA: r = 15 - ai;
      4'hB: begin r = (ai * 2) % 16; c = ai / 8; end
      4'hC: begin r = ai / 2; c = ai % 2; end
      4'hD: begin r = (ai * 2) % 16 + ai / 8; c = ai / 8; end
      4'hE: begin r = ai / 2 + (ai % 2) * 8; c = ai % 2; end
      default: r = bi;
    endcase
    return {c[0], r[3:0]};
  endfunction

  // Called at a negedge with an empty FIFO; request accepted, checked, popped.
  task automatic send_one(input string tag, input logic [3:0] op, a, b,
                          input logic [3:0] er, input logic ec, ez);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, out_result, er);
    chk({tag, "_c"},   out_carry, ec);
    chk({tag, "_z"},   out_zero, ez);
    @(negedge clk);
    exp_cnt++;
    chk({tag, "_cnt"}, op_count, exp_cnt[7:0]);
    chk({tag, "_empty"}, out_valid, 0);
  endtask

  initial begin
    logic [4:0] exp_q[$];
    logic [4:0] e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;

    // reset state
    @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("post_rst_rdy", in_ready, 1);
    chk("post_rst_vld", out_valid, 0);
    chk("post_rst_cnt", op_count, 0);
    chk("post_rst_res", out_result, 0);

    // basic ops
    send_one("add", 4'h0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0);
    send_one("nor", 4'h7, 4'h5, 4'hA, 4'h0, 1'b0, 1'b1);
    send_one("sub", 4'h1, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0);
    send_one("dec", 4'h3, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'hB; in_a = 4'h9; in_b = 4'h0;
    chk("bp_rdy0", in_ready, 1);
    @(negedge clk);
    in_op = 4'hE; in_a = 4'h1;
    chk("bp_rdy1", in_ready, 1);
    chk("bp_head_res", out_result, 4'h2);
    chk("bp_head_c", out_carry, 1);
    @(negedge clk);
    in_op = 4'h6; in_a = 4'hF; in_b = 4'hF;
    chk("bp_full", in_ready, 0);
    chk("bp_hold_res", out_result, 4'h2);
    @(negedge clk);
    chk("bp_still_full", in_ready, 0);
    chk("bp_stable_res", out_result, 4'h2);
    chk("bp_stable_c", out_carry, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy_back", in_ready, 1);
    chk("bp_pop2_res", out_result, 4'h8);
    chk("bp_pop2_c", out_carry, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_pop3_vld", out_valid, 1);
    chk("bp_pop3_res", out_result, 4'h0);
    chk("bp_pop3_z", out_zero, 1);
    chk("bp_pop3_c", out_carry, 0);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    chk("bp_cnt", op_count, 8'd7);

    // reset with a full FIFO and a request presented during reset
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'h0; in_a = 4'h1; in_b = 4'h1;
    @(negedge clk);
    in_a = 4'h2; in_b = 4'h2;
    @(negedge clk);
    chk("fill_full", in_ready, 0);
    in_a = 4'h5; in_b = 4'h5;
    rst = 1'b1; #1;
    chk("rst2_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("rst2_rdy_after", in_ready, 1);
    chk("rst2_vld", out_valid, 0);
    chk("rst2_cnt", op_count, 0);
    chk("rst2_res", out_result, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_no_stale", out_valid, 0);
    exp_cnt = 0;

    // streaming: all 16 opcodes, one per cycle
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        chk("strm_vld", out_valid, 1);
        chk("strm_res", out_result, e[3:0]);
        chk("strm_c", out_carry, e[4]);
        chk("strm_z", out_zero, (e[3:0] == 4'h0));
      end
      if (i < 20) begin
        chk("strm_rdy", in_ready, 1);
        in_valid = 1'b1; in_op = 4'(i % 16);
        in_a = 4'($urandom_range(0, 15)); in_b = 4'($urandom_range(0, 15));
        exp_q.push_back(ref_alu(in_op, in_a, in_b));
      end else in_valid = 1'b0;
      @(negedge clk);
    end
    chk("strm_cnt", op_count, 8'd20);
    exp_cnt = 20;

    // run op_count up to 254 then across the wrap
    in_valid = 1'b1; in_op = 4'h0; in_a = 4'h1; in_b = 4'h1;
    repeat (234) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("cnt_fe", op_count, 8'hFE);
    exp_cnt = 254;
    send_one("w1", 4'hF, 4'h0, 4'h3, 4'h3, 1'b0, 1'b0);
    send_one("w2", 4'h2, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1);
    send_one("w3", 4'hD, 4'h9, 4'h0, 4'h3, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
